// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and the immediate format encoding for the
// pipelined immediate generator.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_Z    = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle. slave is the generator's
// view, master the producer/consumer side.
interface imm_gen_pipe_if #(
    parameter int XLEN = 64
);
    import imm_gen_pkg::*;

    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [31:0]     instr_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] imm_o;
    fmt_e            fmt_o;
    logic            illegal_o;

    modport slave (
        input  flush_i, valid_i, instr_i, ready_i,
        output ready_o, valid_o, imm_o, fmt_o, illegal_o
    );

    modport master (
        output flush_i, valid_i, instr_i, ready_i,
        input  ready_o, valid_o, imm_o, fmt_o, illegal_o
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder. Defining IMM_GEN_ZICSR_EN
// adds CSR immediate (fmt Z) and CSR address decode on SYSTEM opcodes.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64,
    parameter bit RV64 = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [5:0] shamt;
    logic       is_shift;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign shamt    = RV64 ? instr[25:20] : {1'b0, instr[24:20]};
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRX);

    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = XLEN'($signed(instr[31:20]));
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                if (opcode == OPC_OP_IMM_32 && !RV64) begin
                    illegal = 1'b1;
                end else if (is_shift) begin
                    // bit 25 is only a valid shamt bit for 64-bit shifts
                    fmt     = FMT_SH;
                    imm     = XLEN'(shamt);
                    illegal = instr[25] && (!RV64 || opcode == OPC_OP_IMM_32);
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            end
`ifdef IMM_GEN_ZICSR_EN
            OPC_SYSTEM: begin
                if (funct3[2] && funct3[1:0] != 2'b00) begin
                    fmt = FMT_Z;
                    imm = XLEN'(instr[19:15]);
                end else if (!funct3[2] && funct3[1:0] != 2'b00) begin
                    fmt = FMT_I;
                    imm = XLEN'(instr[31:20]);
                end
            end
`else
            OPC_SYSTEM: begin
            end
`endif
            OPC_OP, OPC_OP_32, OPC_MISC_MEM: begin
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) imm = '0;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: one output register plus one skid entry,
// so ready_o depends only on local state and never on ready_i.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64,
    parameter bit RV64 = 1'b1
) (
    input logic          clk_i,
    input logic          rst_i,
    imm_gen_pipe_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } res_t;

    localparam res_t RES_ZERO = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_ill;
    res_t            dec_res;
    res_t            out_q;
    res_t            skid_q;
    logic            out_vld;
    logic            skid_vld;
    logic            in_xfer;
    logic            out_xfer;

    imm_decode #(.XLEN(XLEN), .RV64(RV64)) u_dec (
        .instr   (bus.instr_i),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    assign dec_res  = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_ill};
    assign in_xfer  = bus.valid_i && !skid_vld;
    assign out_xfer = out_vld && bus.ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_vld  <= 1'b0;
            out_q    <= RES_ZERO;
            skid_vld <= 1'b0;
            skid_q   <= RES_ZERO;
        end else if (bus.flush_i) begin
            out_vld  <= 1'b0;
            out_q    <= RES_ZERO;
            skid_vld <= 1'b0;
        end else if (!out_vld || out_xfer) begin
            // output slot frees up: older skid entry goes first
            if (skid_vld) begin
                out_q    <= skid_q;
                skid_vld <= 1'b0;
            end else if (in_xfer) begin
                out_q   <= dec_res;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_q   <= dec_res;
            skid_vld <= 1'b1;
        end
    end

    assign bus.ready_o   = !skid_vld;
    assign bus.valid_o   = out_vld;
    assign bus.imm_o     = out_q.imm;
    assign bus.fmt_o     = out_q.fmt;
    assign bus.illegal_o = out_q.illegal;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator in the ID stage.
- Decodes the RV32I/RV64I immediate formats (I, S, B, U, J and shift-amount) from a 32-bit instruction and sign-extends the result to XLEN.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so it can run at full throughput between IF/ID and ID/EX under stalls and flushes.

Parameters:
- XLEN, 64, output immediate width; legal values are 32 and 64.
- RV64, 1, enables OP-IMM-32 decode and 6-bit shamt; must be 0 when XLEN=32.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous pipeline flush; discards all held entries.
- valid_i  input  1  instr_i is valid.
- ready_o  output  1  block can accept an instruction this cycle.
- instr_i  input  32  raw instruction.
- valid_o  output  1  imm_o, fmt_o and illegal_o are valid.
- ready_i  input  1  downstream accepts the output this cycle.
- imm_o  output  XLEN  sign- or zero-extended immediate.
- fmt_o  output  3  format code: NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6, Z=7.
- illegal_o  output  1  opcode is unrecognised, or shamt is out of range.

Behaviour:
- Reset (rst_i low, asynchronous): valid_o=0, imm_o=0, fmt_o=NONE, illegal_o=0, skid entry empty. ready_o=1 from the first cycle after rst_i rises.
- Transfer rules: input transfers when valid_i && ready_o; output transfers when valid_o && ready_i. Latency is 1 cycle from input transfer to valid_o.
- Output stability: while valid_o && !ready_i, imm_o, fmt_o and illegal_o are held stable.
- Skid buffer: when the output register is occupied and stalled, an incoming instruction is captured in the skid entry. ready_o = !skid_valid, taken from a register (no combinational path from ready_i). On the next output transfer, the skid entry moves to the output register. Order is always preserved.
- Simultaneous in/out transfer with an empty skid entry: the output register takes the new result and valid_o stays 1.
- flush_i:
  - Clears the output register and skid entry next edge: valid_o=0, imm_o=0, fmt_o=NONE.
  - Takes precedence over an input transfer in the same cycle; the input is dropped.
  - ready_o=1 on the following cycle.
- Decode by opcode[6:0]:
  - 0000011 LOAD, 1100111 JALR, and 0010011 OP-IMM (except shifts): I-type, imm = sext(instr[31:20]).
  - 0011011 OP-IMM-32, only when RV64=1: decoded as OP-IMM. When RV64=0 it is illegal.
  - Shifts (OP-IMM funct3 001/101; OP-IMM-32 likewise): SH, imm = zext(shamt).
    - shamt is instr[25:20] when RV64=1, instr[24:20] otherwise.
    - RV64=0 with instr[25]=1: illegal_o=1.
    - OP-IMM-32 with instr[25]=1: illegal_o=1.
  - 0100011: S-type, imm = sext({instr[31:25], instr[11:7]}).
  - 1100011: B-type, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111 LUI and 0010111 AUIPC: U-type, imm = sext({instr[31:12], 12'b0}). Bits above 31 are copies of bit 31.
  - 1101111: J-type, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011, 0111011, 0001111, 1110011: fmt NONE, imm 0, illegal 0.
  - Any other opcode: fmt NONE, imm 0, illegal_o=1.
- When illegal_o=1, imm_o is 0.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- Defined: opcode 1110011 with funct3 101/110/111 decodes as fmt Z, imm = zext(instr[19:15]); funct3 001/010/011 decodes as I-type, imm = zext(instr[31:20]) (CSR address).
- Undefined: 1110011 always gives fmt NONE, imm 0, illegal 0, and fmt code 7 never appears.

Decomposition:
- Package imm_gen_pkg: opcode localparams, fmt_e enum (3-bit), funct3 shift constants.
- Sub-module imm_decode: purely combinational; maps instr to {imm, fmt, illegal}, parametrised by XLEN/RV64.
- imm_gen_pipe: instantiates imm_decode and implements the output register, skid entry and flush logic.

Test Plan:
- XLEN=64. addi 0xFFF00093, then sw 0x00112423, both with ready_i=1 → imm 0xFFFF_FFFF_FFFF_FFFF fmt I, then imm 0x8 fmt S, one per cycle, latency 1.
- beq 0xFE000EE3 → imm 0xFFFF_FFFF_FFFF_FFFC fmt B. lui 0x800000B7 → imm 0xFFFF_FFFF_8000_0000 fmt U.
- slli 0x03F09093: at RV64=1 → imm 63 fmt SH illegal 0. At XLEN=32, RV64=0 → illegal_o=1, imm 0.
- Back-to-back stream of 6 instructions with ready_i held low for 3 cycles → ready_o drops the cycle after the skid entry fills. All 6 appear in order, and outputs stay stable while stalled.
- flush_i asserted with both entries full and valid_i=1 → valid_o=0 next cycle, ready_o=1, flushed and same-cycle instructions never appear. Repeat with rst_i low mid-stream → outputs zeroed immediately, without waiting for a clock edge.
- IMM_GEN_ZICSR_EN defined: csrrwi 0x3001D073 → fmt Z, imm 0x3. Undefined → fmt NONE, illegal 0.
